tug_of_war_ctrl: RTL and testbench
==================================

Name: tug_of_war_ctrl

Overview:
- Game controller and sequencer for the 16x16 red/green LED matrix in a two-player tug-of-war.
- Edge-detects the left (LK) and right (RK) player buttons and tracks the marker position on row 0.
- Runs the round/match state machine, keeps both scores, and drives the full RedPixels/GrnPixels arrays for the display driver.
- Replaces the chain of per-light cells with one centralised FSM plus position register.

Parameters:
- CENTER, 8, serve column of the marker on row 0 (legal 1..14).
- WIN_SCORE, 7, rounds needed to win the match (legal 1..8).
- HOLD_CYCLES, 4, cycles spent in ROUND_WIN before the next serve (legal ≥1).

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- LK  input  1  left player button, pre-synchronised, level, high = pressed.
- RK  input  1  right player button, pre-synchronised, level, high = pressed.
- key  input  1  serve/restart button, pre-synchronised, level.
- RedPixels  output  [15:0][15:0]  red LED array, indexed [row][col].
- GrnPixels  output  [15:0][15:0]  green LED array, indexed [row][col].
- winner  output  2  00 none, 10 left, 01 right; nonzero only in ROUND_WIN/MATCH_OVER.
- match_over  output  1  high while in MATCH_OVER.

Behaviour:
- One clock domain; reset is synchronous and active-high; clock port is `clock`, reset port is `reset`.
- Edge detect: prevLK, prevRK and prevKey registers; press = input & ~prev.
  - Prev registers reset to 1, so a button held through reset never counts until it has been released and pressed again.
  - Holding a button produces exactly one press.
- Registers: state, pos (4b), lscore (4b), rscore (4b), hold_cnt (sized to fit HOLD_CYCLES).
- Reset values: state=IDLE, pos=CENTER, lscore=rscore=0, hold_cnt=0. Pixel outputs derive from state with no extra latency, so the first cycle after reset shows only Red[0][CENTER]=1; winner=00; match_over=0.
- IDLE:
  - Marker shown; LK/RK presses ignored.
  - key press → PLAY next cycle.
- PLAY:
  - LK press only → pos+1. RK press only → pos−1. Both in the same cycle → no move.
  - key is ignored.
  - Position is visible on the pixels the cycle after the press cycle.
  - LK press with pos=14 → pos=15, lscore+1, state=ROUND_WIN, winner=10, hold_cnt=0.
  - RK press with pos=1 → pos=0, rscore+1, state=ROUND_WIN, winner=01, hold_cnt=0.
- ROUND_WIN:
  - All presses ignored.
  - hold_cnt increments each cycle. When hold_cnt==HOLD_CYCLES−1, next cycle pos=CENTER and winner cleared.
  - Next state is MATCH_OVER if the winning score == WIN_SCORE; winner then stays asserted.
  - Otherwise next state is PLAY (auto-serve, no key needed).
- MATCH_OVER:
  - LK/RK presses ignored.
  - key press → lscore=rscore=0, pos=CENTER, winner=00, state=IDLE.
- Scores saturate at WIN_SCORE and never wrap.
- Rendering: all pixels 0 except the following.
  - IDLE/PLAY: Red[0][pos]=1.
  - ROUND_WIN: Grn[0][15] (left win) or Grn[0][0] (right win); no red on row 0.
  - MATCH_OVER: Grn[0][15:8]=all 1 (left) or Grn[0][7:0]=all 1 (right).
  - Scores, all states: Grn[15][15−i]=1 for i<lscore; Grn[15][i]=1 for i<rscore.
- Reset asserted in any state, including mid-round and mid-hold, overrides everything and returns to reset values next cycle.
- Presses coinciding with a state transition are consumed by the current state's rule only; nothing is queued.

Test Plan:
- Reset held with LK=1, then reset deasserted with LK still 1 → pos stays 8, no move until LK is released and re-pressed; Red[0][8]=1 only.
- IDLE, 3 LK pulses → pos unchanged at 8; key pulse → PLAY; 7 LK pulses → pos=15, ROUND_WIN, winner=10, Grn[0][15]=1, Grn[15][15]=1; 4 cycles later PLAY, pos=8, winner=00.
- PLAY pos=8, LK and RK rise in the same cycle → pos stays 8; RK alone 8 times → rscore=1, Grn[15][0]=1, winner=01.
- LK held high for 20 cycles in PLAY → exactly one step, pos 8→9.
- WIN_SCORE=2: left wins two rounds → MATCH_OVER, match_over=1, Grn[0][15:8]=FF, Grn[15][15:14]=11; LK ignored; key pulse → IDLE, scores 0, pos=8.
- Reset pulsed during ROUND_WIN hold (hold_cnt=2) → next cycle IDLE, scores 0, winner=00, only Red[0][8] lit.

Source files
------------

// File: rtl/tug_of_war_ctrl.sv
// Tug-of-war game controller: button edge detect, round/match FSM, scores,
// and full 16x16 red/green pixel rendering for the LED matrix driver.
module tug_of_war_ctrl #(
    parameter int CENTER      = 8,
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              LK,
    input  logic              RK,
    input  logic              key,
    output logic [15:0][15:0] RedPixels,
    output logic [15:0][15:0] GrnPixels,
    output logic [1:0]        winner,
    output logic              match_over
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [3:0]    CTR       = 4'(CENTER);
    localparam logic [3:0]    WSC       = 4'(WIN_SCORE);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, PLAY, ROUND_WIN, MATCH_OVER} state_t;

    typedef struct packed {
        state_t        state;
        logic [3:0]    pos;
        logic [3:0]    lscore;
        logic [3:0]    rscore;
        logic [HW-1:0] hold_cnt;
    } ctx_t;

    localparam ctx_t CTX_RST = '{state: IDLE, pos: CTR, lscore: 4'd0,
                                 rscore: 4'd0, hold_cnt: '0};

    ctx_t r, rn;
    logic prev_lk, prev_rk, prev_key;
    logic lk_p, rk_p, key_p;
    logic left_side;
    logic [15:0] lbar, rbar;

    assign lk_p  = LK  & ~prev_lk;
    assign rk_p  = RK  & ~prev_rk;
    assign key_p = key & ~prev_key;

    // Who won: the marker sits on the goal column during the hold, and the
    // pos has been re-centred by match over, so fall back to the scores there.
    assign left_side = (r.state == ROUND_WIN) ? (r.pos == 4'd15) : (r.lscore == WSC);

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WSC) ? s : s + 4'd1;
    endfunction

    // Prev registers come out of reset high so a held button is not a press.
    always_ff @(posedge clock) begin
        if (reset) begin
            r        <= CTX_RST;
            prev_lk  <= 1'b1;
            prev_rk  <= 1'b1;
            prev_key <= 1'b1;
        end else begin
            r        <= rn;
            prev_lk  <= LK;
            prev_rk  <= RK;
            prev_key <= key;
        end
    end

    always_comb begin
        rn = r;
        case (r.state)
            IDLE: begin
                if (key_p) rn.state = PLAY;
            end
            PLAY: begin
                if (lk_p && !rk_p) begin
                    rn.pos = r.pos + 4'd1;
                    if (r.pos == 4'd14) begin
                        rn.lscore   = sat_inc(r.lscore);
                        rn.state    = ROUND_WIN;
                        rn.hold_cnt = '0;
                    end
                end else if (rk_p && !lk_p) begin
                    rn.pos = r.pos - 4'd1;
                    if (r.pos == 4'd1) begin
                        rn.rscore   = sat_inc(r.rscore);
                        rn.state    = ROUND_WIN;
                        rn.hold_cnt = '0;
                    end
                end
            end
            ROUND_WIN: begin
                rn.hold_cnt = r.hold_cnt + 1'b1;
                if (r.hold_cnt == HOLD_LAST) begin
                    rn.pos      = CTR;
                    rn.hold_cnt = '0;
                    rn.state    = (((left_side ? r.lscore : r.rscore)) == WSC) ? MATCH_OVER : PLAY;
                end
            end
            MATCH_OVER: begin
                if (key_p) rn = CTX_RST;
            end
            default: rn = CTX_RST;
        endcase
    end

    for (genvar i = 0; i < 16; i++) begin : g_bar
        assign lbar[15-i] = (4'(i) < r.lscore);
        assign rbar[i]    = (4'(i) < r.rscore);
    end

    always_comb begin
        RedPixels     = '0;
        GrnPixels     = '0;
        winner        = 2'b00;
        match_over    = 1'b0;
        GrnPixels[15] = lbar | rbar;
        case (r.state)
            IDLE, PLAY: RedPixels[0][r.pos] = 1'b1;
            ROUND_WIN: begin
                winner = left_side ? 2'b10 : 2'b01;
                if (left_side) GrnPixels[0][15] = 1'b1;
                else           GrnPixels[0][0]  = 1'b1;
            end
            MATCH_OVER: begin
                winner     = left_side ? 2'b10 : 2'b01;
                match_over = 1'b1;
                if (left_side) GrnPixels[0][15:8] = 8'hFF;
                else           GrnPixels[0][7:0]  = 8'hFF;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tug_of_war_ctrl.sv
// Directed vector bench for tug_of_war_ctrl (WIN_SCORE=2 so a full match fits).
module tb_tug_of_war_ctrl;

    logic              clock = 1'b0;
    logic              reset, LK, RK, key;
    logic [15:0][15:0] RedPixels, GrnPixels;
    logic [1:0]        winner;
    logic              match_over;

    int checks = 0;
    int errors = 0;

    tug_of_war_ctrl #(.CENTER(8), .WIN_SCORE(2), .HOLD_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .LK(LK), .RK(RK), .key(key),
        .RedPixels(RedPixels), .GrnPixels(GrnPixels),
        .winner(winner), .match_over(match_over)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst, lk, rk, ky;
        logic [15:0] red0, grn0, grn15;
        logic [1:0]  win;
        logic        mo;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic rst, lk, rk, ky,
                                input logic [15:0] red0, grn0, grn15,
                                input logic [1:0] win, input logic mo);
        vec_t v;
        v.rst = rst; v.lk = lk; v.rk = rk; v.ky = ky;
        v.red0 = red0; v.grn0 = grn0; v.grn15 = grn15; v.win = win; v.mo = mo;
        return v;
    endfunction

    // Drive one cycle of inputs, then check the state the edge produced.
    task automatic apply(input vec_t v, input string tag);
        logic [15:0][15:0] er, eg;
        reset = v.rst; LK = v.lk; RK = v.rk; key = v.ky;
        @(posedge clock);
        #1;
        er = '0; eg = '0;
        er[0] = v.red0; eg[0] = v.grn0; eg[15] = v.grn15;
        checks++;
        if (RedPixels !== er) begin
            errors++;
            $display("FAIL %s red got %h want %h", tag, RedPixels, er);
        end
        checks++;
        if (GrnPixels !== eg) begin
            errors++;
            $display("FAIL %s grn got %h want %h", tag, GrnPixels, eg);
        end
        checks++;
        if (winner !== v.win) begin
            errors++;
            $display("FAIL %s winner got %b want %b", tag, winner, v.win);
        end
        checks++;
        if (match_over !== v.mo) begin
            errors++;
            $display("FAIL %s match_over got %b want %b", tag, match_over, v.mo);
        end
    endtask

    initial begin
        logic [15:0] one;
        one = 16'h1;
        reset = 1'b1; LK = 1'b0; RK = 1'b0; key = 1'b0;

        // Buttons held through reset must not count after release of reset.
        vq.push_back(mk(1,1,0,1, 16'h0100,0,0,0,0));
        vq.push_back(mk(1,1,0,1, 16'h0100,0,0,0,0));
        vq.push_back(mk(0,1,0,1, 16'h0100,0,0,0,0));
        vq.push_back(mk(0,0,0,1, 16'h0100,0,0,0,0));
        vq.push_back(mk(0,1,0,1, 16'h0100,0,0,0,0));
        vq.push_back(mk(0,0,0,0, 16'h0100,0,0,0,0));
        // IDLE ignores LK
        for (int k = 0; k < 3; k++) begin
            vq.push_back(mk(0,1,0,0, 16'h0100,0,0,0,0));
            vq.push_back(mk(0,0,0,0, 16'h0100,0,0,0,0));
        end
        vq.push_back(mk(0,0,0,1, 16'h0100,0,0,0,0));
        vq.push_back(mk(0,0,0,0, 16'h0100,0,0,0,0));
        for (int p = 9; p <= 14; p++) begin
            vq.push_back(mk(0,1,0,0, one << p,0,0,0,0));
            vq.push_back(mk(0,0,0,0, one << p,0,0,0,0));
        end
        // Left round win, four hold cycles, presses ignored
        vq.push_back(mk(0,1,0,0, 0,16'h8000,16'h8000,2'b10,0));
        vq.push_back(mk(0,0,0,0, 0,16'h8000,16'h8000,2'b10,0));
        vq.push_back(mk(0,1,0,0, 0,16'h8000,16'h8000,2'b10,0));
        vq.push_back(mk(0,0,0,0, 0,16'h8000,16'h8000,2'b10,0));
        vq.push_back(mk(0,1,0,0, 16'h0100,0,16'h8000,0,0));
        vq.push_back(mk(0,1,0,0, 16'h0100,0,16'h8000,0,0));
        vq.push_back(mk(0,0,0,0, 16'h0100,0,16'h8000,0,0));
        // Simultaneous presses cancel
        vq.push_back(mk(0,1,1,0, 16'h0100,0,16'h8000,0,0));
        vq.push_back(mk(0,0,0,0, 16'h0100,0,16'h8000,0,0));
        // LK held 20 cycles: one step only
        for (int k = 0; k < 20; k++)
            vq.push_back(mk(0,1,0,0, 16'h0200,0,16'h8000,0,0));
        vq.push_back(mk(0,0,0,0, 16'h0200,0,16'h8000,0,0));
        vq.push_back(mk(0,0,1,0, 16'h0100,0,16'h8000,0,0));
        vq.push_back(mk(0,0,0,0, 16'h0100,0,16'h8000,0,0));
        // Right wins a round
        for (int p = 7; p >= 1; p--) begin
            vq.push_back(mk(0,0,1,0, one << p,0,16'h8000,0,0));
            vq.push_back(mk(0,0,0,0, one << p,0,16'h8000,0,0));
        end
        vq.push_back(mk(0,0,1,0, 0,16'h0001,16'h8001,2'b01,0));
        for (int k = 0; k < 3; k++)
            vq.push_back(mk(0,0,0,0, 0,16'h0001,16'h8001,2'b01,0));
        vq.push_back(mk(0,0,0,0, 16'h0100,0,16'h8001,0,0));
        // Left reaches WIN_SCORE -> match over
        for (int p = 9; p <= 14; p++) begin
            vq.push_back(mk(0,1,0,0, one << p,0,16'h8001,0,0));
            vq.push_back(mk(0,0,0,0, one << p,0,16'h8001,0,0));
        end
        vq.push_back(mk(0,1,0,0, 0,16'h8000,16'hC001,2'b10,0));
        for (int k = 0; k < 3; k++)
            vq.push_back(mk(0,0,0,0, 0,16'h8000,16'hC001,2'b10,0));
        vq.push_back(mk(0,0,0,0, 0,16'hFF00,16'hC001,2'b10,1));
        vq.push_back(mk(0,1,0,0, 0,16'hFF00,16'hC001,2'b10,1));
        vq.push_back(mk(0,0,0,0, 0,16'hFF00,16'hC001,2'b10,1));
        vq.push_back(mk(0,0,0,1, 16'h0100,0,0,0,0));
        vq.push_back(mk(0,0,0,0, 16'h0100,0,0,0,0));

        foreach (vq[i]) apply(vq[i], $sformatf("vec%0d", i));

        // Reset in the middle of a round-win hold
        apply(mk(0,0,0,1, 16'h0100,0,0,0,0), "rh_serve");
        apply(mk(0,0,0,0, 16'h0100,0,0,0,0), "rh_serve_rel");
        for (int p = 9; p <= 14; p++) begin
            apply(mk(0,1,0,0, one << p,0,0,0,0), $sformatf("rh_step%0d", p));
            apply(mk(0,0,0,0, one << p,0,0,0,0), $sformatf("rh_rel%0d", p));
        end
        apply(mk(0,1,0,0, 0,16'h8000,16'h8000,2'b10,0), "rh_hold0");
        apply(mk(0,0,0,0, 0,16'h8000,16'h8000,2'b10,0), "rh_hold1");
        apply(mk(0,0,0,0, 0,16'h8000,16'h8000,2'b10,0), "rh_hold2");
        apply(mk(1,0,0,0, 16'h0100,0,0,0,0), "rh_reset");
        apply(mk(0,0,0,0, 16'h0100,0,0,0,0), "rh_idle");
        apply(mk(0,1,0,0, 16'h0100,0,0,0,0), "rh_idle_lk");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
